// File: rtl/corr_pkg.sv
// Shared types and helpers for the correlator sequencer: FSM state encoding,
// default sizing and a saturating counter increment.
package corr_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LOAD    = 2'd1,
    WAIT    = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 3;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TIMEOUT = 15;

  // Increment val, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - w);
    return (val == max_v) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/correlator_ctrl_if.sv
// Serial bit stream and correlator handshake bundle. The master side feeds bits
// and returns correlator results; the slave side is the sequencer.
interface correlator_ctrl_if import corr_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [WIDTH-1:0] corr_data;
  logic             corr_load;
  logic             corr_done;
  logic             corr_match;

  modport master (
    output bit_in, bit_valid, corr_done, corr_match,
    input  bit_ready, corr_data, corr_load
  );

  modport slave (
    input  bit_in, bit_valid, corr_done, corr_match,
    output bit_ready, corr_data, corr_load
  );
endinterface

// File: rtl/corr_watchdog.sv
// WAIT-phase watchdog: reloads while the frame is being handed off and counts
// down during WAIT; o_expire is high on the TIMEOUT-th WAIT cycle.
module corr_watchdog import corr_pkg::*; #(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(TIMEOUT - 1);
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire = i_run && (r_cnt == '0);
endmodule

// File: rtl/correlator_ctrl.sv
// Frame sequencer between the serial bit input and the correlator: assembles
// WIDTH bits, strobes the correlator, counts results. Optional WAIT watchdog: CORR_CTRL_WATCHDOG_EN.
module correlator_ctrl import corr_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  correlator_ctrl_if.slave     bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 timeout_err
);
  localparam int IDX_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_corr_data;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_match_cnt;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_done_ok;
  logic             w_expire;

  assign w_accept   = bus.bit_valid && (r_state == COLLECT);
  assign w_last_bit = (r_idx == IDX_W'(WIDTH - 1));
  assign w_done_ok  = bus.corr_done && (r_state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (w_accept && w_last_bit) w_state_next = LOAD;
      LOAD:    w_state_next = WAIT;
      WAIT:    if (w_done_ok || w_expire) w_state_next = COLLECT;
      default: w_state_next = COLLECT;
    endcase
    if (clr) begin
      w_state_next = COLLECT;
    end
  end

  // clr discards a bit offered in the same cycle and leaves corr_data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_corr_data <= '0;
      r_frame_cnt <= '0;
      r_match_cnt <= '0;
    end else if (clr) begin
      r_idx       <= '0;
      r_frame_cnt <= '0;
      r_match_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_corr_data <= {r_corr_data[WIDTH-2:0], bus.bit_in};
        r_idx       <= w_last_bit ? '0 : r_idx + IDX_W'(1);
      end
      if (w_done_ok) begin
        r_frame_cnt <= CNT_W'(sat_inc(32'(r_frame_cnt), CNT_W));
        if (bus.corr_match) begin
          r_match_cnt <= CNT_W'(sat_inc(32'(r_match_cnt), CNT_W));
        end
      end
    end
  end

`ifdef CORR_CTRL_WATCHDOG_EN
  logic r_timeout_err;

  corr_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_load   (r_state == LOAD),
    .i_run    (r_state == WAIT),
    .o_expire (w_expire)
  );

  // A done arriving on the expiry cycle takes precedence over the abort.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_timeout_err <= 1'b0;
    end else if (w_expire && !bus.corr_done) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT);
  assign w_expire         = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  assign bus.bit_ready = (r_state == COLLECT);
  assign bus.corr_load = (r_state == LOAD);
  assign bus.corr_data = r_corr_data;
  assign busy          = (r_state == LOAD) || (r_state == WAIT);
  assign frame_cnt     = r_frame_cnt;
  assign match_cnt     = r_match_cnt;
endmodule
